// File: rtl/div_unit_pkg.sv
// Shared definitions for the multicycle divider: FSM states, iteration count
// and the iteration counter width.
package div_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_e;

   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = 6;

endpackage

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient to LOW (lo), remainder to HIGH (hi),
// with a divide-by-zero pulse back to the control FSM.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   div_state_e state, state_nxt;

   logic [CNT_W-1:0]   count;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   dvs_mag;
   logic               q_neg;
   logic               r_neg;

   logic signed [WIDTH-1:0] dividend_s;
   logic signed [WIDTH-1:0] divisor_s;
   logic [WIDTH:0]          rem_shift;
   logic [WIDTH:0]          rem_trial;

   // Magnitude as an unsigned value; the most negative input maps to itself,
   // which is exactly 2^31 when read as unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
      logic signed [WIDTH-1:0] n;
      n = -v;
      return v[WIDTH-1] ? WIDTH'(n) : WIDTH'(v);
   endfunction

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
      return n ? WIDTH'(-v) : v;
   endfunction

   assign dividend_s = dividend;
   assign divisor_s  = divisor;
   assign busy       = (state != IDLE);

   // One shift-and-trial-subtract step; the top bit of the trial is its sign.
   always_comb begin
      rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
      rem_trial = rem_shift - {1'b0, dvs_mag};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && (divisor != '0)) state_nxt = CALC;
         CALC:    if (count == CNT_W'(DIV_ITERS - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         rem      <= '0;
         quo      <= '0;
         dvs_mag  <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     div_zero <= 1'b1;
                  end else begin
                     quo     <= mag(dividend_s);
                     rem     <= '0;
                     dvs_mag <= mag(divisor_s);
                     q_neg   <= dividend_s[WIDTH-1] ^ divisor_s[WIDTH-1];
                     r_neg   <= dividend_s[WIDTH-1];
                     count   <= '0;
                  end
               end
            end
            CALC: begin
               if (!rem_trial[WIDTH]) begin
                  rem <= rem_trial;
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= rem_shift;
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
               count <= count + CNT_W'(1);
            end
            FIX: begin
               lo   <= neg_if(quo, q_neg);
               hi   <= neg_if(rem[WIDTH-1:0], r_neg);
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
